ex_muldiv: RTL and testbench

Multiply/divide unit in the EX stage of the pipelined MIPS core, one stage upstream of the data-memory stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO against architectural HI/LO registers, with fixed multi-cycle latency and a busy flag. The hazard unit uses the busy flag to stall dependent instructions. MFHI/MFLO read the `hi`/`lo` outputs, which are forwarded into the EX result mux and then on to MEM.

---
 rtl/ex_muldiv.sv | 125 ++++++++++++
 tb/tb_ex_muldiv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: owns the architectural HI/LO registers.
// Results are held pending and committed after a fixed latency.
module ex_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    // Returns {remainder, quotient}; divide by zero yields 0 (never committed).
    function automatic logic [63:0] f_divu(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
    // the dividend's sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    function automatic logic [63:0] f_divs(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        logic [63:0] qr;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        qr = f_divu(ma, mb);
        q  = qr[31:0];
        r  = qr[63:32];
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    op_e                w_op;
    logic               w_accept;
    logic               w_is_md;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [63:0] w_res;
    logic [CNT_W-1:0]   w_cnt_ld;

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi, r_lo;
    logic [31:0]        r_hi_p, r_lo_p;
    logic               r_dz;

    assign w_op     = op_e'(op);
    assign w_is_md  = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                      (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_accept = start && !r_busy && (w_op != OP_NONE) && (w_op != OP_RSVD);
    assign w_prod_s = $signed(rs_val) * $signed(rt_val);
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    always_comb begin
        w_res    = w_prod_s;
        w_cnt_ld = MULT_N;
        case (w_op)
            OP_MULTU: w_res = w_prod_u;
            OP_DIV:   begin w_res = f_divs(rs_val, rt_val); w_cnt_ld = DIV_N; end
            OP_DIVU:  begin w_res = f_divu(rs_val, rt_val); w_cnt_ld = DIV_N; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (r_busy) begin
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!r_dz) begin
                    r_hi <= r_hi_p;
                    r_lo <= r_lo_p;
                end
            end
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (w_accept) begin
            case (w_op)
                OP_MTHI: r_hi <= rs_val;
                OP_MTLO: r_lo <= rs_val;
                default: begin
                    r_busy <= 1'b1;
                    r_cnt  <= w_cnt_ld;
                end
            endcase
        end
    end

    // Pending results only matter while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_md) begin
            r_hi_p <= w_res[63:32];
            r_lo_p <= w_res[31:0];
            r_dz   <= ((w_op == OP_DIV) || (w_op == OP_DIVU)) && (rt_val == 32'd0);
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: predicted HI/LO pairs are queued at issue
// and compared when the unit drops busy.
module tb_ex_muldiv;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sb_q[$];

    ex_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin p = sa * sb; sb_q.push_back(p); end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; sb_q.push_back(p); end
            3'd3: begin
                if (b == 32'd0) sb_q.push_back({m_hi, m_lo});
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    sb_q.push_back({r[31:0], q[31:0]});
                end
            end
            default: begin
                if (b == 32'd0) sb_q.push_back({m_hi, m_lo});
                else begin
                    uq = a / b;
                    ur = a % b;
                    sb_q.push_back({ur, uq});
                end
            end
        endcase
    endfunction

    // Drives one accepted op; returns at the negedge just after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        predict(o, a, b);
        @(negedge clk);
        start = 1'b0; op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    endtask

    // Checks n busy cycles with HI/LO held, then the commit against the scoreboard.
    task automatic wait_commit(input int n);
        logic [63:0] e;
        for (int k = 0; k < n; k++) begin
            chk("busy_hi", 32'(busy), 32'd1);
            chk("hi_hold", hi, m_hi);
            chk("lo_hold", lo, m_lo);
            @(negedge clk);
        end
        chk("busy_done", 32'(busy), 32'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("hi_commit", hi, e[63:32]);
            chk("lo_commit", lo, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_hi", hi, 32'd0);
            chk("rst_lo", lo, 32'd0);
        end

        issue(3'd1, 32'hFFFFFFFE, 32'd3);       wait_commit(MC);
        issue(3'd2, 32'hFFFFFFFE, 32'd3);       wait_commit(MC);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);       wait_commit(DC);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);       wait_commit(DC);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF); wait_commit(DC);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs_val = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", 32'(busy), 32'd0);
        m_hi = 32'h12345678;
        op = 3'd6; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        m_lo = 32'h9ABCDEF0;

        // start low and reserved op have no effect
        start = 1'b0; op = 3'd1; rs_val = 32'd7; rt_val = 32'd9;
        @(negedge clk);
        chk("nostart_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'd7; rs_val = 32'hCAFEF00D;
        @(negedge clk);
        chk("rsvd_busy", 32'(busy), 32'd0);
        chk("rsvd_hi", hi, m_hi);
        chk("rsvd_lo", lo, m_lo);
        start = 1'b0; op = 3'd0;

        // MULT with start held three cycles; trailing MTLO must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs_val = 32'h00012345; rt_val = 32'hFFFF0003;
        predict(3'd1, 32'h00012345, 32'hFFFF0003);
        @(negedge clk);
        op = 3'd6; rs_val = 32'hDEADBEEF; rt_val = 32'd0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_commit(MC - 2);

        // Divide by zero leaves HI/LO untouched
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs_val = 32'h11;
        @(negedge clk);
        op = 3'd6; rs_val = 32'h22;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        m_hi = 32'h11; m_lo = 32'h22;
        issue(3'd3, 32'h12345678, 32'd0); wait_commit(DC);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        issue(3'd4, 32'hFFFFFFFF, 32'd0); wait_commit(DC);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i == 3) ? 32'd1 : $urandom;
            if (i == 4) rb = 32'hFFFFFFFF;
            issue(ro, ra, rb);
            wait_commit((ro <= 3'd2) ? MC : DC);
        end

        // Reset on the third busy cycle aborts the MULT
        issue(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_busy", 32'(busy), 32'd0);
            chk("post_abort_hi", hi, 32'd0);
            chk("post_abort_lo", lo, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
